// File: rtl/exp_table_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : exp_table_sched_if
// Brief    : Frame request, table handshake and amplitude result bundle for
//            the exp_table round-robin scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface exp_table_sched_if #(
    parameter int NCH = 4
);
    logic                 sample_tick;
    logic [5*NCH-1:0]     level_in;
    logic [NCH-1:0]       ch_mask;
    logic [6:0]           tbl_exp;
    logic                 tbl_en;
    logic                 tbl_ready;
    logic [4:0]           tbl_in;
    logic [7*NCH-1:0]     amp_out;
    logic                 busy;
    logic                 frame_done;
    logic                 overrun;

    // Environment side: envelope logic, exp_table output and mixer.
    modport master (
        output sample_tick, level_in, ch_mask, tbl_exp,
        input  tbl_en, tbl_ready, tbl_in, amp_out, busy, frame_done, overrun
    );

    modport slave (
        input  sample_tick, level_in, ch_mask, tbl_exp,
        output tbl_en, tbl_ready, tbl_in, amp_out, busy, frame_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/exp_table_sched.sv
`default_nettype none
// ============================================================================
// Module   : exp_table_sched
// Brief    : Round-robin sharing of one exp_table lookup pipeline among four
//            channels; captures each result into a per-channel amp register.
// Revision : 1.0  initial release
// ============================================================================
module exp_table_sched #(
    parameter int NCH = 4,
    parameter int LAT = 9
) (
    input  logic               MHz10,
    input  logic               rst,
    exp_table_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_LAST  = 2'd3
    } state_t;

    state_t                     r_state;
    logic [2:0]                 r_cnt;
    logic [5*NCH-1:0]           r_level;
    logic [NCH-1:0]             r_mask;
    logic [LAT-1:0]             r_tag_v;
    logic [LAT-1:0][1:0]        r_tag_ch;
    logic [7*NCH-1:0]           r_amp;
    logic                       r_frame_done;
    logic                       r_overrun;

    logic                       w_busy;
    logic                       w_ready;
    logic [1:0]                 w_slot;
    logic                       w_push_v;
    logic [4:0]                 w_lvl;
    logic                       w_cap;

    assign w_busy   = (r_state != S_IDLE);
    assign w_ready  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_slot   = r_cnt[1:0];
    assign w_push_v = (r_state == S_ISSUE) && r_mask[w_slot];
    // Stage LAT-1 of the tag line lines up with the table's exp_out.
    assign w_cap    = w_busy && r_tag_v[LAT-1];

    always_comb begin
        w_lvl = 5'd0;
        for (int i = 0; i < NCH; i++) begin
            if (w_slot == 2'(i)) begin
                w_lvl = r_level[5*i +: 5];
            end
        end
    end

    assign bus.tbl_en     = w_busy;
    assign bus.tbl_ready  = w_ready;
    assign bus.tbl_in     = w_push_v ? w_lvl : 5'd0;
    assign bus.busy       = w_busy;
    assign bus.amp_out    = r_amp;
    assign bus.frame_done = r_frame_done;
    assign bus.overrun    = r_overrun;

    always_ff @(posedge MHz10) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_level      <= '0;
            r_mask       <= '0;
            r_tag_v      <= '0;
            r_tag_ch     <= '0;
            r_amp        <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_overrun    <= w_busy && bus.sample_tick;

            if (w_ready) begin
                r_tag_v  <= {r_tag_v[LAT-2:0], w_push_v};
                r_tag_ch <= {r_tag_ch[LAT-2:0], w_slot};
            end

            for (int i = 0; i < NCH; i++) begin
                if (w_cap && (r_tag_ch[LAT-1] == 2'(i))) begin
                    r_amp[7*i +: 7] <= bus.tbl_exp;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.sample_tick) begin
                        r_level <= bus.level_in;
                        r_mask  <= bus.ch_mask;
                        r_cnt   <= 3'd0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_cnt == 3'(NCH-1)) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == 3'(LAT-2)) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_LAST;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_LAST: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= 3'd0;
                    r_frame_done <= 1'b1;
                    for (int i = 0; i < NCH; i++) begin
                        if (!r_mask[i]) begin
                            r_amp[7*i +: 7] <= 7'd0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exp_table_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_table_sched
// Brief    : Self-checking bench for exp_table_sched with an exp_table model.
// Revision : 1.0  initial release
// ============================================================================
module tb_exp_table_sched;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [27:0] amp_model;

    exp_table_sched_if #(.NCH(4)) bus ();

    exp_table_sched #(.NCH(4), .LAT(9)) dut (
        .MHz10 (clk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table lookup: amplitude grows with the square of the level index.
    function automatic logic [6:0] ref_exp(input logic [4:0] x);
        int v;
        v = (127 * int'(x) * int'(x)) / 961;
        return 7'(v);
    endfunction

    // exp_table model: 9-deep shift line, stale contents at power-up.
    logic [4:0] stage [9] = '{5'd17, 5'd29, 5'd4, 5'd22, 5'd9, 5'd31, 5'd13, 5'd26, 5'd11};
    always @(posedge clk) begin
        if (bus.tbl_en && bus.tbl_ready) begin
            for (int s = 8; s > 0; s--) stage[s] <= stage[s-1];
            stage[0] <= bus.tbl_in;
        end
    end
    assign bus.tbl_exp = bus.tbl_en ? ref_exp(stage[8]) : 7'd0;

    // Frame-level reference: k is cycles since the accepted tick.
    function automatic logic [27:0] m_amp(input int k, input logic [19:0] lv,
                                          input logic [3:0] mk, input logic [27:0] old);
        logic [27:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (mk[i] && k >= 11 + i) r[7*i +: 7] = ref_exp(lv[5*i +: 5]);
            else if (!mk[i] && k >= 14) r[7*i +: 7] = 7'd0;
        end
        return r;
    endfunction

    function automatic logic [4:0] m_in(input int k, input logic [19:0] lv, input logic [3:0] mk);
        if (k >= 1 && k <= 4 && mk[k-1]) return lv[5*(k-1) +: 5];
        return 5'd0;
    endfunction

    // {tbl_en, tbl_ready, busy, frame_done} expected at cycle k (overrun separate).
    function automatic logic [3:0] m_ctl(input int k);
        logic en;
        en = (k >= 1 && k <= 13);
        return {en, (k >= 1 && k <= 12), en, (k == 14)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.sample_tick = 1'b0;
        bus.level_in = '0;
        bus.ch_mask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b want 00000",
                     {bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun});
        end
        checks++;
        if (bus.tbl_in !== 5'd0) begin
            errors++;
            $display("FAIL reset_tbl_in got %0d want 0", bus.tbl_in);
        end
        checks++;
        if (bus.amp_out !== 28'd0) begin
            errors++;
            $display("FAIL reset_amp got %h want 0", bus.amp_out);
        end
        rst = 1'b0;
        amp_model = '0;
    endtask

    task automatic test_basic();
        logic [19:0] lv;
        logic [3:0]  mk;
        int          busy_cnt;
        lv = {5'd3, 5'd10, 5'd16, 5'd31};
        mk = 4'b1111;
        busy_cnt = 0;
        bus.sample_tick = 1'b1; bus.level_in = lv; bus.ch_mask = mk;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) bus.sample_tick = 1'b0;
            if (bus.busy === 1'b1) busy_cnt++;
            checks++;
            if ({bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun} !== {m_ctl(k), 1'b0}) begin
                errors++;
                $display("FAIL basic_ctl k=%0d got %b want %b", k,
                         {bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun}, {m_ctl(k), 1'b0});
            end
            checks++;
            if (bus.tbl_in !== m_in(k, lv, mk)) begin
                errors++;
                $display("FAIL basic_tbl_in k=%0d got %0d want %0d", k, bus.tbl_in, m_in(k, lv, mk));
            end
            checks++;
            if (bus.amp_out !== m_amp(k, lv, mk, amp_model)) begin
                errors++;
                $display("FAIL basic_amp k=%0d got %h want %h", k, bus.amp_out, m_amp(k, lv, mk, amp_model));
            end
        end
        checks++;
        if (bus.amp_out !== {7'd1, 7'd13, 7'd33, 7'd127}) begin
            errors++;
            $display("FAIL basic_final got %h want %h", bus.amp_out, {7'd1, 7'd13, 7'd33, 7'd127});
        end
        checks++;
        if (busy_cnt != 13) begin
            errors++;
            $display("FAIL basic_busy_len got %0d want 13", busy_cnt);
        end
        amp_model = m_amp(14, lv, mk, amp_model);
    endtask

    task automatic test_masked();
        logic [19:0] lv;
        logic [3:0]  mk;
        lv = {4{5'd31}};
        mk = 4'b0101;
        bus.sample_tick = 1'b1; bus.level_in = lv; bus.ch_mask = mk;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) bus.sample_tick = 1'b0;
            checks++;
            if (bus.tbl_in !== m_in(k, lv, mk)) begin
                errors++;
                $display("FAIL masked_tbl_in k=%0d got %0d want %0d", k, bus.tbl_in, m_in(k, lv, mk));
            end
            checks++;
            if (bus.amp_out !== m_amp(k, lv, mk, amp_model)) begin
                errors++;
                $display("FAIL masked_amp k=%0d got %h want %h", k, bus.amp_out, m_amp(k, lv, mk, amp_model));
            end
        end
        checks++;
        if (bus.amp_out !== {7'd0, 7'd127, 7'd0, 7'd127}) begin
            errors++;
            $display("FAIL masked_final got %h want %h", bus.amp_out, {7'd0, 7'd127, 7'd0, 7'd127});
        end
        amp_model = m_amp(14, lv, mk, amp_model);
    endtask

    task automatic test_back_to_back();
        logic [19:0] lv [2];
        lv[0] = {4{5'd31}};
        lv[1] = {5'd16, 5'd3, 5'd2, 5'd0};
        bus.sample_tick = 1'b1; bus.level_in = lv[0]; bus.ch_mask = 4'b1111;
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                if (k == 1) bus.sample_tick = 1'b0;
                checks++;
                if ({bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun} !== {m_ctl(k), 1'b0}) begin
                    errors++;
                    $display("FAIL b2b_ctl f=%0d k=%0d got %b want %b", f, k,
                             {bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun}, {m_ctl(k), 1'b0});
                end
                checks++;
                if (bus.amp_out !== m_amp(k, lv[f], 4'b1111, amp_model)) begin
                    errors++;
                    $display("FAIL b2b_amp f=%0d k=%0d got %h want %h", f, k, bus.amp_out,
                             m_amp(k, lv[f], 4'b1111, amp_model));
                end
            end
            amp_model = m_amp(14, lv[f], 4'b1111, amp_model);
            if (f == 0) begin
                bus.sample_tick = 1'b1; bus.level_in = lv[1];
            end
        end
        checks++;
        if (bus.amp_out !== {7'd33, 7'd1, 7'd0, 7'd0}) begin
            errors++;
            $display("FAIL b2b_final got %h want %h", bus.amp_out, {7'd33, 7'd1, 7'd0, 7'd0});
        end
    endtask

    task automatic test_overrun();
        logic [19:0] lv;
        lv = 20'($urandom);
        bus.sample_tick = 1'b1; bus.level_in = lv; bus.ch_mask = 4'b1111;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            bus.sample_tick = (k == 5 || k == 13);
            bus.level_in = 20'($urandom);
            checks++;
            if ({bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun} !==
                {m_ctl(k), (k == 6 || k == 14)}) begin
                errors++;
                $display("FAIL overrun_ctl k=%0d got %b want %b", k,
                         {bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun},
                         {m_ctl(k), (k == 6 || k == 14)});
            end
            checks++;
            if (bus.amp_out !== m_amp(k, lv, 4'b1111, amp_model)) begin
                errors++;
                $display("FAIL overrun_amp k=%0d got %h want %h", k, bus.amp_out, m_amp(k, lv, 4'b1111, amp_model));
            end
        end
        amp_model = m_amp(14, lv, 4'b1111, amp_model);
    endtask

    task automatic test_mid_reset();
        logic [19:0] lv;
        bus.sample_tick = 1'b1; bus.level_in = 20'($urandom); bus.ch_mask = 4'b1111;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) bus.sample_tick = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        amp_model = '0;
        checks++;
        if ({bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun, bus.tbl_in, bus.amp_out} !== 38'd0) begin
            errors++;
            $display("FAIL midrst_zero got en=%b rdy=%b busy=%b done=%b ovr=%b in=%0d amp=%h want all 0",
                     bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun, bus.tbl_in, bus.amp_out);
        end
        lv = {5'd8, 5'd7, 5'd6, 5'd5};
        bus.sample_tick = 1'b1; bus.level_in = lv;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) bus.sample_tick = 1'b0;
            checks++;
            if (bus.amp_out !== m_amp(k, lv, 4'b1111, amp_model)) begin
                errors++;
                $display("FAIL midrst_amp k=%0d got %h want %h", k, bus.amp_out, m_amp(k, lv, 4'b1111, amp_model));
            end
        end
        checks++;
        if (bus.amp_out !== {7'd8, 7'd6, 7'd4, 7'd3}) begin
            errors++;
            $display("FAIL midrst_final got %h want %h", bus.amp_out, {7'd8, 7'd6, 7'd4, 7'd3});
        end
        amp_model = m_amp(14, lv, 4'b1111, amp_model);
    endtask

    task automatic test_idle();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus.level_in = 20'($urandom);
            bus.ch_mask  = 4'($urandom);
            checks++;
            if ({bus.tbl_en, bus.tbl_ready, bus.tbl_in} !== 7'd0) begin
                errors++;
                $display("FAIL idle_tbl c=%0d got en=%b rdy=%b in=%0d want 0", c, bus.tbl_en, bus.tbl_ready, bus.tbl_in);
            end
            checks++;
            if (bus.amp_out !== amp_model) begin
                errors++;
                $display("FAIL idle_amp c=%0d got %h want %h", c, bus.amp_out, amp_model);
            end
        end
    endtask

    task automatic test_random();
        logic [19:0] lv;
        logic [3:0]  mk;
        for (int f = 0; f < 25; f++) begin
            lv = 20'($urandom);
            mk = 4'($urandom);
            bus.sample_tick = 1'b1; bus.level_in = lv; bus.ch_mask = mk;
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                if (k == 1) bus.sample_tick = 1'b0;
                checks++;
                if ({bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun} !== {m_ctl(k), 1'b0}) begin
                    errors++;
                    $display("FAIL rand_ctl f=%0d k=%0d got %b want %b", f, k,
                             {bus.tbl_en, bus.tbl_ready, bus.busy, bus.frame_done, bus.overrun}, {m_ctl(k), 1'b0});
                end
                checks++;
                if (bus.tbl_in !== m_in(k, lv, mk)) begin
                    errors++;
                    $display("FAIL rand_tbl_in f=%0d k=%0d got %0d want %0d", f, k, bus.tbl_in, m_in(k, lv, mk));
                end
                checks++;
                if (bus.amp_out !== m_amp(k, lv, mk, amp_model)) begin
                    errors++;
                    $display("FAIL rand_amp f=%0d k=%0d got %h want %h", f, k, bus.amp_out, m_amp(k, lv, mk, amp_model));
                end
            end
            amp_model = m_amp(14, lv, mk, amp_model);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_masked();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
